// File: rtl/reg_alu_pkg.sv
// Shared definitions for the register-bank/ALU instruction sequencer:
// FSM states, opcode classes, instruction field layout and ALU function codes.
package reg_alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        RESP
    } state_e;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [1:0] OP_ITYPE_HI = 2'b01;

    // Field LSB positions and widths; imm and rd/funct overlap by design.
    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_LSB = 0;
    localparam int OPC_W     = 6;
    localparam int REG_W     = 5;
    localparam int IMM_W     = 16;
    localparam int FUNCT_W   = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB,
        ALU_PASSA = 4'hC,
        ALU_PASSB = 4'hD,
        ALU_MUL  = 4'hE,
        ALU_NOP  = 4'hF
    } alu_func_e;

    function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/reg_alu_decode.sv
// Combinational instruction decoder: register indices, ALU controls and the
// illegal flag (unknown opcode or any referenced register outside the bank).
module reg_alu_decode
    import reg_alu_pkg::*;
#(
    parameter int NUM_REGS = 18
) (
    input  logic [31:0] instr,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic [4:0]  dest,
    output logic [3:0]  alu_func,
    output logic        alu_b_sel,
    output logic [31:0] alu_imm,
    output logic        illegal
);

    localparam logic [REG_W:0] REG_LIM = (REG_W+1)'(NUM_REGS);

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;

    assign opcode = instr[OPC_LSB +: OPC_W];
    assign rs     = instr[RS_LSB +: REG_W];
    assign rt     = instr[RT_LSB +: REG_W];
    assign rd     = instr[RD_LSB +: REG_W];

    function automatic logic reg_ok(input logic [REG_W-1:0] idx);
        return {1'b0, idx} < REG_LIM;
    endfunction

    always_comb begin
        src1      = rs;
        src2      = rt;
        dest      = rd;
        alu_func  = instr[FUNCT_LSB +: FUNCT_W];
        alu_b_sel = 1'b0;
        alu_imm   = sext_imm(instr[IMM_LSB +: IMM_W]);
        illegal   = 1'b0;
        if (opcode == OP_RTYPE) begin
            illegal = !reg_ok(rs) || !reg_ok(rt) || !reg_ok(rd);
        end else if (opcode[OPC_W-1 -: 2] == OP_ITYPE_HI) begin
            // Port 2 is unused for immediates; park it on r0.
            src2      = '0;
            dest      = rt;
            alu_func  = opcode[3:0];
            alu_b_sel = 1'b1;
            illegal   = !reg_ok(rs) || !reg_ok(rt);
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/reg_alu_seq.sv
// Multi-cycle sequencer: accepts one instruction per handshake, holds the bank
// read addresses and ALU controls, waits ALU_LAT cycles, then writes back once.
module reg_alu_seq
    import reg_alu_pkg::*;
#(
    parameter int NUM_REGS = 18,
    parameter int ALU_LAT  = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       src_reg1,
    output logic [4:0]       src_reg2,
    output logic [3:0]       alu_func,
    output logic             alu_b_sel,
    output logic [31:0]      alu_imm,
    input  logic [31:0]      alu_result,
    output logic [4:0]       dest_reg,
    output logic [31:0]      wrt_data,
    output logic             wrt_en,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    logic [4:0]  dec_src1;
    logic [4:0]  dec_src2;
    logic [4:0]  dec_dest;
    logic [3:0]  dec_func;
    logic        dec_b_sel;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    reg_alu_decode #(.NUM_REGS(NUM_REGS)) u_decode (
        .instr     (instr),
        .src1      (dec_src1),
        .src2      (dec_src2),
        .dest      (dec_dest),
        .alu_func  (dec_func),
        .alu_b_sel (dec_b_sel),
        .alu_imm   (dec_imm),
        .illegal   (dec_illegal)
    );

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [4:0]       src_reg1_q, src_reg1_d;
    logic [4:0]       src_reg2_q, src_reg2_d;
    logic [3:0]       alu_func_q, alu_func_d;
    logic             alu_b_sel_q, alu_b_sel_d;
    logic [31:0]      alu_imm_q, alu_imm_d;
    logic [4:0]       dest_dec_q, dest_dec_d;
    logic             illegal_q, illegal_d;
    logic [4:0]       dest_reg_q, dest_reg_d;
    logic [31:0]      wrt_data_q, wrt_data_d;
    logic             wrt_en_q, wrt_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        src_reg1_d    = src_reg1_q;
        src_reg2_d    = src_reg2_q;
        alu_func_d    = alu_func_q;
        alu_b_sel_d   = alu_b_sel_q;
        alu_imm_d     = alu_imm_q;
        dest_dec_d    = dest_dec_q;
        illegal_d     = illegal_q;
        dest_reg_d    = dest_reg_q;
        wrt_data_d    = wrt_data_q;
        wrt_en_d      = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        retired_cnt_d = retired_cnt_q;
        err_cnt_d     = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    src_reg1_d  = dec_src1;
                    src_reg2_d  = dec_src2;
                    alu_func_d  = dec_func;
                    alu_b_sel_d = dec_b_sel;
                    alu_imm_d   = dec_imm;
                    dest_dec_d  = dec_dest;
                    illegal_d   = dec_illegal;
                    state_d     = READ;
                end
            end
            READ: begin
                if (illegal_q) begin
                    state_d       = RESP;
                    done_d        = 1'b1;
                    err_d         = 1'b1;
                    retired_cnt_d = sat_inc(retired_cnt_q);
                    err_cnt_d     = sat_inc(err_cnt_q);
                end else begin
                    state_d = EXEC;
                    cnt_d   = LAT_M1;
                end
            end
            EXEC: begin
                // Pulses are registered here so they coincide with the WB state.
                if (cnt_q == 4'd0) begin
                    wrt_data_d    = alu_result;
                    dest_reg_d    = dest_dec_q;
                    wrt_en_d      = (dest_dec_q != 5'd0);
                    done_d        = 1'b1;
                    retired_cnt_d = sat_inc(retired_cnt_q);
                    state_d       = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB:      state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            src_reg1_q    <= '0;
            src_reg2_q    <= '0;
            alu_func_q    <= '0;
            alu_b_sel_q   <= 1'b0;
            alu_imm_q     <= '0;
            dest_dec_q    <= '0;
            illegal_q     <= 1'b0;
            dest_reg_q    <= '0;
            wrt_data_q    <= '0;
            wrt_en_q      <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            retired_cnt_q <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            src_reg1_q    <= src_reg1_d;
            src_reg2_q    <= src_reg2_d;
            alu_func_q    <= alu_func_d;
            alu_b_sel_q   <= alu_b_sel_d;
            alu_imm_q     <= alu_imm_d;
            dest_dec_q    <= dest_dec_d;
            illegal_q     <= illegal_d;
            dest_reg_q    <= dest_reg_d;
            wrt_data_q    <= wrt_data_d;
            wrt_en_q      <= wrt_en_d;
            done_q        <= done_d;
            err_q         <= err_d;
            retired_cnt_q <= retired_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign src_reg1    = src_reg1_q;
    assign src_reg2    = src_reg2_q;
    assign alu_func    = alu_func_q;
    assign alu_b_sel   = alu_b_sel_q;
    assign alu_imm     = alu_imm_q;
    assign dest_reg    = dest_reg_q;
    assign wrt_data    = wrt_data_q;
    // Suppress a write-back that coincides with reset so the bank never sees it.
    assign wrt_en      = wrt_en_q & ~rst;
    assign done        = done_q;
    assign err         = err_q;
    assign retired_cnt = retired_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule
